// File: rtl/reg_writeback_queue.sv
// Writeback queue for the 16 x 16-bit register file: buffers MEM/ALU writebacks in program
// order and drains one per cycle. Define WB_BYPASS_EN to enable the pending-write lookup ports.
module reg_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     mem_valid_i,
  input  logic [AW-1:0]            mem_reg_i,
  input  logic [DW-1:0]            mem_data_i,
  output logic                     mem_ready_o,
  input  logic                     alu_valid_i,
  input  logic [AW-1:0]            alu_reg_i,
  input  logic [DW-1:0]            alu_data_i,
  output logic                     alu_ready_o,
  input  logic                     wb_stall_i,
  output logic                     wb_en_o,
  output logic [AW-1:0]            wb_reg_o,
  output logic [DW-1:0]            wb_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  input  logic [AW-1:0]            src1_reg_i,
  input  logic [AW-1:0]            src2_reg_i,
  output logic                     src1_hit_o,
  output logic [DW-1:0]            src1_data_o,
  output logic                     src2_hit_o,
  output logic [DW-1:0]            src2_data_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] reg_q  [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          mem_enq, alu_enq, deq;
  logic [PW-1:0] alu_slot;

  // Readiness uses start-of-cycle occupancy; a same-cycle drain is deliberately not credited.
  assign mem_ready_o = (count_q < CW'(DEPTH));
  assign alu_ready_o = mem_valid_i ? (count_q <= CW'(DEPTH - 2)) : (count_q < CW'(DEPTH));

  // Register 0 is hardwired, so its writes are acknowledged but never stored.
  assign mem_enq  = mem_valid_i && mem_ready_o && (mem_reg_i != '0);
  assign alu_enq  = alu_valid_i && alu_ready_o && (alu_reg_i != '0);
  assign deq      = (count_q != '0) && !wb_stall_i;
  assign alu_slot = tail_q + PW'(mem_enq);

  assign wb_en_o   = deq;
  assign wb_reg_o  = (count_q != '0) ? reg_q[head_q]  : '0;
  assign wb_data_o = (count_q != '0) ? data_q[head_q] : '0;
  assign count_o   = count_q;

  always_comb begin
    head_d  = head_q + PW'(deq);
    tail_d  = tail_q + PW'(mem_enq) + PW'(alu_enq);
    count_d = count_q + CW'(mem_enq) + CW'(alu_enq) - CW'(deq);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (mem_enq) begin
        reg_q[tail_q]  <= mem_reg_i;
        data_q[tail_q] <= mem_data_i;
      end
      if (alu_enq) begin
        reg_q[alu_slot]  <= alu_reg_i;
        data_q[alu_slot] <= alu_data_i;
      end
    end
  end

`ifdef WB_BYPASS_EN
  // Walk from head to tail so the newest matching entry overrides older ones.
  always_comb begin
    src1_hit_o  = 1'b0;
    src1_data_o = '0;
    src2_hit_o  = 1'b0;
    src2_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if ((src1_reg_i != '0) && (reg_q[head_q + PW'(i)] == src1_reg_i)) begin
          src1_hit_o  = 1'b1;
          src1_data_o = data_q[head_q + PW'(i)];
        end
        if ((src2_reg_i != '0) && (reg_q[head_q + PW'(i)] == src2_reg_i)) begin
          src2_hit_o  = 1'b1;
          src2_data_o = data_q[head_q + PW'(i)];
        end
      end
    end
  end
`else
  logic unused_src;
  assign unused_src  = ^{src1_reg_i, src2_reg_i};
  assign src1_hit_o  = 1'b0;
  assign src1_data_o = '0;
  assign src2_hit_o  = 1'b0;
  assign src2_data_o = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed scenarios plus random traffic against a queue model.
module tb_reg_writeback_queue;
  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_valid, alu_valid, wb_stall;
  logic [AW-1:0] mem_reg, alu_reg, src1_reg, src2_reg;
  logic [DW-1:0] mem_data, alu_data;
  logic          mem_ready, alu_ready, wb_en, src1_hit, src2_hit;
  logic [AW-1:0] wb_reg;
  logic [DW-1:0] wb_data, src1_data, src2_data;
  logic [CW-1:0] count;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;
  ent_t mq[$];

  always #5 clk = ~clk;

  reg_writeback_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .mem_valid_i(mem_valid), .mem_reg_i(mem_reg), .mem_data_i(mem_data), .mem_ready_o(mem_ready),
    .alu_valid_i(alu_valid), .alu_reg_i(alu_reg), .alu_data_i(alu_data), .alu_ready_o(alu_ready),
    .wb_stall_i(wb_stall), .wb_en_o(wb_en), .wb_reg_o(wb_reg), .wb_data_o(wb_data),
    .count_o(count),
    .src1_reg_i(src1_reg), .src2_reg_i(src2_reg),
    .src1_hit_o(src1_hit), .src1_data_o(src1_data),
    .src2_hit_o(src2_hit), .src2_data_o(src2_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs from the pending-write list and this cycle's inputs.
  task automatic model_check();
    int n;
    logic e_mr, e_ar, e_en, e_h1, e_h2;
    logic [AW-1:0] e_reg;
    logic [DW-1:0] e_dat, e_d1, e_d2;
    n     = mq.size();
    e_mr  = (n < DEPTH);
    e_ar  = mem_valid ? (n <= DEPTH - 2) : (n < DEPTH);
    e_en  = (n != 0) && !wb_stall;
    e_reg = (n != 0) ? mq[0].r : '0;
    e_dat = (n != 0) ? mq[0].d : '0;
    e_h1 = 1'b0; e_d1 = '0; e_h2 = 1'b0; e_d2 = '0;
`ifdef WB_BYPASS_EN
    for (int i = 0; i < n; i++) begin
      if (src1_reg != 0 && mq[i].r == src1_reg) begin e_h1 = 1'b1; e_d1 = mq[i].d; end
      if (src2_reg != 0 && mq[i].r == src2_reg) begin e_h2 = 1'b1; e_d2 = mq[i].d; end
    end
`endif
    chk("mem_ready", 32'(mem_ready), 32'(e_mr));
    chk("alu_ready", 32'(alu_ready), 32'(e_ar));
    chk("wb_en",     32'(wb_en),     32'(e_en));
    chk("wb_reg",    32'(wb_reg),    32'(e_reg));
    chk("wb_data",   32'(wb_data),   32'(e_dat));
    chk("count",     32'(count),     n);
    chk("src1_hit",  32'(src1_hit),  32'(e_h1));
    chk("src1_data", 32'(src1_data), 32'(e_d1));
    chk("src2_hit",  32'(src2_hit),  32'(e_h2));
    chk("src2_data", 32'(src2_data), 32'(e_d2));
  endtask

  task automatic model_update();
    int  n;
    logic m_acc, a_acc;
    ent_t e;
    if (rst) begin
      mq.delete();
      return;
    end
    n     = mq.size();
    m_acc = mem_valid && (n < DEPTH);
    a_acc = alu_valid && (mem_valid ? (n <= DEPTH - 2) : (n < DEPTH));
    if (n != 0 && !wb_stall) void'(mq.pop_front());
    if (m_acc && mem_reg != 0) begin e.r = mem_reg; e.d = mem_data; mq.push_back(e); end
    if (a_acc && alu_reg != 0) begin e.r = alu_reg; e.d = alu_data; mq.push_back(e); end
  endtask

  // One clock cycle: drive after the rising edge, check on the falling edge, then advance the model.
  task automatic step(input logic r, input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md,
                      input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                      input logic st, input logic [AW-1:0] s1, input logic [AW-1:0] s2);
    @(posedge clk);
    #1;
    rst = r; mem_valid = mv; mem_reg = mr; mem_data = md;
    alu_valid = av; alu_reg = ar; alu_data = ad; wb_stall = st;
    src1_reg = s1; src2_reg = s2;
    @(negedge clk);
    model_check();
    model_update();
  endtask

  task automatic idle(input logic st);
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, st, 4'd0, 4'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0);
  endtask

  task automatic push_mem(input logic [AW-1:0] r, input logic [DW-1:0] d, input logic st);
    step(1'b0, 1'b1, r, d, 1'b0, 4'd0, 16'h0, st, 4'd0, 4'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_valid = 0; alu_valid = 0; wb_stall = 0;
    mem_reg = 0; alu_reg = 0; mem_data = 0; alu_data = 0; src1_reg = 0; src2_reg = 0;

    // Single write through an empty queue
    do_reset();
    idle(1'b0);
    chk("rst_count", 32'(count), 0);
    chk("rst_wb_en", 32'(wb_en), 0);
    chk("rst_mem_ready", 32'(mem_ready), 1);
    chk("rst_alu_ready", 32'(alu_ready), 1);
    push_mem(4'd3, 16'h1234, 1'b0);
    chk("t1_mem_ready", 32'(mem_ready), 1);
    idle(1'b0);
    chk("t1_wb_en", 32'(wb_en), 1);
    chk("t1_wb_reg", 32'(wb_reg), 3);
    chk("t1_wb_data", 32'(wb_data), 32'h1234);
    chk("t1_count", 32'(count), 1);
    idle(1'b0);
    chk("t1_count_after", 32'(count), 0);
    chk("t1_wb_en_after", 32'(wb_en), 0);

    // Dual enqueue: MEM first, ALU second
    step(1'b0, 1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd6, 16'hBBBB, 1'b0, 4'd0, 4'd0);
    chk("t2_mem_ready", 32'(mem_ready), 1);
    chk("t2_alu_ready", 32'(alu_ready), 1);
    idle(1'b0);
    chk("t2_first_reg", 32'(wb_reg), 5);
    chk("t2_first_data", 32'(wb_data), 32'hAAAA);
    idle(1'b0);
    chk("t2_second_reg", 32'(wb_reg), 6);
    chk("t2_second_data", 32'(wb_data), 32'hBBBB);
    idle(1'b0);

    // Fill under stall, then drain and wrap
    for (int i = 1; i <= 4; i++) push_mem(4'(i), 16'(16'h0100 * i), 1'b1);
    step(1'b0, 1'b1, 4'd9, 16'h9999, 1'b1, 4'd10, 16'hAAAA, 1'b1, 4'd0, 4'd0);
    chk("t3_full_mem_ready", 32'(mem_ready), 0);
    chk("t3_full_alu_ready", 32'(alu_ready), 0);
    chk("t3_full_count", 32'(count), 4);
    for (int i = 1; i <= 4; i++) begin
      idle(1'b0);
      chk("t3_drain_reg", 32'(wb_reg), i);
      chk("t3_drain_en", 32'(wb_en), 1);
    end
    for (int i = 8; i <= 13; i++) push_mem(4'(i), 16'(16'h1000 + i), 1'b0);
    idle(1'b0);
    chk("t3_wrap_reg", 32'(wb_reg), 13);
    chk("t3_wrap_data", 32'(wb_data), 32'h100D);
    idle(1'b0);

    // Three occupied: only MEM fits
    for (int i = 1; i <= 3; i++) push_mem(4'(i), 16'(16'h0200 + i), 1'b1);
    step(1'b0, 1'b1, 4'd11, 16'h0B0B, 1'b1, 4'd12, 16'h0C0C, 1'b1, 4'd0, 4'd0);
    chk("t4_mem_ready", 32'(mem_ready), 1);
    chk("t4_alu_ready", 32'(alu_ready), 0);
    idle(1'b1);
    chk("t4_count", 32'(count), 4);
    for (int i = 0; i < 4; i++) idle(1'b0);
    chk("t4_last_reg", 32'(wb_reg), 11);
    idle(1'b0);

    // Register 0 dropped; reset discards pending entries
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 4'd0);
    chk("t5_alu_ready", 32'(alu_ready), 1);
    idle(1'b0);
    chk("t5_count", 32'(count), 0);
    chk("t5_wb_en", 32'(wb_en), 0);
    for (int i = 1; i <= 3; i++) push_mem(4'(i + 4), 16'(16'h0300 + i), 1'b1);
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 4'd0);
    chk("t5_pre_rst_count", 32'(count), 3);
    idle(1'b0);
    chk("t5_post_rst_count", 32'(count), 0);
    chk("t5_post_rst_wb_en", 32'(wb_en), 0);
    chk("t5_post_rst_mem_ready", 32'(mem_ready), 1);
    chk("t5_post_rst_alu_ready", 32'(alu_ready), 1);

    // Bypass lookup with two pending writes to the same register
    push_mem(4'd7, 16'h0011, 1'b1);
    push_mem(4'd7, 16'h0022, 1'b1);
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 4'd0);
`ifdef WB_BYPASS_EN
    chk("t6_src1_hit", 32'(src1_hit), 1);
    chk("t6_src1_data", 32'(src1_data), 32'h0022);
`else
    chk("t6_src1_hit", 32'(src1_hit), 0);
    chk("t6_src1_data", 32'(src1_data), 0);
`endif
    chk("t6_src2_hit", 32'(src2_hit), 0);
    for (int i = 0; i < 3; i++) idle(1'b0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 16'($urandom),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 16'($urandom),
           ($urandom_range(0, 9) < 4),
           4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
